seg_scan_driver: RTL



---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_hex7.sv | 14 +
 rtl/seg_scan_driver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern,
// hex glyph table and segment bit positions (all patterns active-low).
package seg_pkg;

  // Segment bit positions inside the 7-bit pattern {g,f,e,d,c,b,a}
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex7.sv
// Combinational nibble to active-low seven-segment pattern.
module seg_hex7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup of the glyph
  always_comb begin
    seg_n = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered frame,
// per-digit blanking and decimal points, active-low outputs.
// Optional feature macro: SEG_LZ_SUPPRESS_EN (leading-zero suppression).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic                  pending,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]         tick_q, tick_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     disp_blank_q, disp_blank_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_supp;
  logic [DIGITS-1:0]     supp_mask;
  logic [6:0]            hex_seg;

  assign slot_end  = (tick_q == TW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));

  // Slot counter and digit index
  always_comb begin
    tick_d = tick_q + TW'(1);
    idx_d  = idx_q;
    if (slot_end) begin
      tick_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: load fills pending, frame boundary commits pending to display.
  // A load on the commit cycle still commits the old pending contents.
  always_comb begin
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    if (frame_end && pending_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      pending_d    = 1'b1;
    end
  end

  // Select the current digit's nibble and attribute bits
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = disp_blank_q[i];
        cur_supp  = supp_mask[i];
      end
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  // Leading-zero mask: scan down from the top digit until a non-zero nibble
  always_comb begin
    logic seen;
    int unsigned i;
    supp_mask = '0;
    seen      = 1'b0;
    for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
      i = DIGITS - 1 - j;
      if (disp_val_q[4*i +: 4] != 4'h0) seen = 1'b1;
      if (!seen && !disp_dp_q[i]) supp_mask[i] = 1'b1;
    end
  end
`else
  assign supp_mask = '0;
`endif

  seg_hex7 u_hex (
    .nibble (cur_nib),
    .seg_n  (hex_seg)
  );

  // Output pattern for the current slot, anode held off on the slot's first cycle
  always_comb begin
    seg_d = hex_seg;
    dp_d  = ~cur_dp;
    an_d  = '1;
    if (cur_blank || cur_supp) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (tick_q != '0) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx_q == IW'(i)) an_d[i] = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign pending = pending_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;

endmodule
